// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the radix-2 sequential multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, one multiplier bit per RUN cycle.
// Define SEQ_MULTIPLIER_SIGNED_EN to add the is_signed port (two's complement mode).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t               r_state;
  state_t               w_nextState;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cntNext;
  logic                 w_lastStep;
  logic                 w_accept;
  logic                 w_isSignedIn;
  logic                 r_isSigned;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_mcandInit;
  logic [2*WIDTH-1:0]   w_partial;
  logic [2*WIDTH-1:0]   w_accNext;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  assign w_isSignedIn = is_signed;
`else
  assign w_isSignedIn = 1'b0;
`endif

  assign w_accept    = start & ready;
  assign w_cntNext   = r_cnt + 1'b1;
  assign w_lastStep  = (w_cntNext == LAST);
  assign w_mcandInit = {{WIDTH{w_isSignedIn & a[WIDTH-1]}}, a};
  assign w_partial   = r_mplier[0] ? r_mcand : '0;
  // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so the last partial is subtracted.
  assign w_accNext   = (w_lastStep && r_isSigned) ? (r_acc - w_partial) : (r_acc + w_partial);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    ready       = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = RUN;
      end
      RUN: begin
        ready = 1'b0;
        busy  = 1'b1;
        if (w_lastStep) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = start ? RUN : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operands are captured on acceptance so later input changes cannot disturb a running product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_isSigned <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      product    <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_isSigned <= w_isSignedIn;
      r_acc      <= '0;
      r_mcand    <= w_mcandInit;
      r_mplier   <= b;
    end else if (r_state == RUN) begin
      r_cnt    <= w_cntNext;
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_lastStep) product <= w_accNext;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=8) with a product scoreboard.
// Signed cases are built when SEQ_MULTIPLIER_SIGNED_EN is defined.
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic           isSigned;
`endif
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  logic [2*W-1:0] expQ[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    .is_signed(isSigned),
`endif
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int sx;
    int sy;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    return (2*W)'(sx * sy);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit push);
    a     = x;
    b     = y;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    isSigned = s;
`endif
    start = 1'b1;
    if (push) expQ.push_back(model(x, y, s));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitForDone(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Scoreboard: every done pulse pops and compares the oldest expected product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneCount++;
      checkOutput("sb_expected_pending", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) checkOutput("sb_product", 32'(product), 32'(expQ.pop_front()));
    end
  end

  initial begin
    int n;
    int snap;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    isSigned = 1'b0;
`endif
    #1;
    checkOutput("reset_ready",   32'(ready),   32'd1);
    checkOutput("reset_busy",    32'(busy),    32'd0);
    checkOutput("reset_done",    32'(done),    32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] 3 x 5 latency and handshake");
    applyStimulus(8'd3, 8'd5, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("run_busy_%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("run_ready_%0d", i), 32'(ready), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("3x5_done",    32'(done),    32'd1);
    checkOutput("3x5_ready",   32'(ready),   32'd1);
    checkOutput("3x5_busy",    32'(busy),    32'd0);
    checkOutput("3x5_product", 32'(product), 32'h000F);
    @(posedge clk); #1;
    checkOutput("3x5_done_one_cycle", 32'(done),    32'd0);
    checkOutput("3x5_product_held",   32'(product), 32'h000F);

    $display("[TB] max operands then back-to-back zero");
    applyStimulus(8'd255, 8'd255, 1'b0, 1'b1);
    waitForDone(n);
    checkOutput("max_latency", 32'(n),       32'd8);
    checkOutput("max_product", 32'(product), 32'hFE01);
    checkOutput("max_ready",   32'(ready),   32'd1);
    applyStimulus(8'd0, 8'd200, 1'b0, 1'b1);
    checkOutput("b2b_accepted_busy", 32'(busy), 32'd1);
    waitForDone(n);
    checkOutput("b2b_latency", 32'(n),       32'd8);
    checkOutput("b2b_product", 32'(product), 32'h0000);
    @(posedge clk); #1;

    $display("[TB] start while busy is ignored");
    snap = doneCount;
    applyStimulus(8'd10, 8'd10, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("busy_ready_low", 32'(ready), 32'd0);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitForDone(n);
    checkOutput("ignored_latency", 32'(n),       32'd4);
    checkOutput("ignored_product", 32'(product), 32'd100);
    repeat (12) begin @(posedge clk); #1; end
    checkOutput("ignored_single_done", 32'(doneCount - snap), 32'd1);
    checkOutput("ignored_product_held", 32'(product), 32'd100);

    $display("[TB] reset during RUN");
    applyStimulus(8'd7, 8'd9, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",    32'(busy),    32'd0);
    checkOutput("abort_done",    32'(done),    32'd0);
    checkOutput("abort_ready",   32'(ready),   32'd1);
    checkOutput("abort_product", 32'(product), 32'd0);
    snap = doneCount;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    checkOutput("abort_no_done", 32'(doneCount - snap), 32'd0);
    checkOutput("abort_idle_ready", 32'(ready), 32'd1);
    applyStimulus(8'd2, 8'd2, 1'b0, 1'b1);
    waitForDone(n);
    checkOutput("post_reset_latency", 32'(n),       32'd8);
    checkOutput("post_reset_product", 32'(product), 32'd4);
    @(posedge clk); #1;

    $display("[TB] operands toggling during RUN");
    applyStimulus(8'd12, 8'd11, 1'b0, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    checkOutput("toggle_latency", 32'(n),       32'd8);
    checkOutput("toggle_product", 32'(product), 32'd132);
    @(posedge clk); #1;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    $display("[TB] signed mode");
    applyStimulus(8'hFD, 8'd5, 1'b1, 1'b1);
    waitForDone(n);
    checkOutput("s_neg3x5_latency", 32'(n),       32'd8);
    checkOutput("s_neg3x5_product", 32'(product), 32'hFFF1);
    @(posedge clk); #1;
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b1);
    waitForDone(n);
    checkOutput("s_min_product", 32'(product), 32'h4000);
    @(posedge clk); #1;
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1);
    waitForDone(n);
    checkOutput("s_off_product", 32'(product), 32'hFE01);
    @(posedge clk); #1;
`endif

    repeat (3) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
